// File: rtl/timer_pkg.sv
// Shared types and constants for the HH:MM:SS BCD stopwatch/timer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int BCD_W  = 4;
    localparam int TIME_W = 24;

    localparam logic [BCD_W-1:0] SEC_T_MAX = 4'd5;
    localparam logic [BCD_W-1:0] MIN_T_MAX = 4'd5;
    localparam logic [BCD_W-1:0] DIGIT_MAX = 4'd9;

    localparam int SEC_O_LSB = 0;
    localparam int SEC_T_LSB = 4;
    localparam int MIN_O_LSB = 8;
    localparam int MIN_T_LSB = 12;
    localparam int HR_O_LSB  = 16;
    localparam int HR_T_LSB  = 20;

    function automatic logic digitOk(input logic [BCD_W-1:0] d, input logic [BCD_W-1:0] max);
        return d <= max;
    endfunction

endpackage

// File: rtl/timer_core_bcd_digit.sv
// One BCD digit with load, clear and up/down count; carry/borrow mark the wrap point while enabled.
module bcd_digit
    import timer_pkg::*;
#(
    parameter logic [BCD_W-1:0] MAX = 4'd9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             clr,
    input  logic             ld,
    input  logic [BCD_W-1:0] ld_val,
    output logic [BCD_W-1:0] q,
    output logic             carry,
    output logic             borrow
);

    logic [BCD_W-1:0] q_q;
    logic [BCD_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (ld) begin
            q_d = ld_val;
        end else if (en) begin
            if (dir) begin
                q_d = (q_q == '0) ? MAX : q_q - 4'd1;
            end else begin
                q_d = (q_q == MAX) ? '0 : q_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q      = q_q;
    assign carry  = en && !dir && (q_q == MAX);
    assign borrow = en && dir && (q_q == '0);

endmodule

// File: rtl/timer_core.sv
// Stopwatch/timer core: BCD HH:MM:SS up/down counter with preset load, lap capture and expiry.
module timer_core
    import timer_pkg::*;
#(
    parameter int HR_MAX = 99,
    parameter bit LAP_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    input  logic              mode,
    input  logic              load,
    input  logic [TIME_W-1:0] load_bcd,
    input  logic              lap,
    output logic [TIME_W-1:0] time_bcd,
    output logic [TIME_W-1:0] lap_bcd,
    output logic              lap_valid,
    output logic              running,
    output logic              done,
    output logic              wrap,
    output logic              load_err
);

    localparam logic [BCD_W-1:0] HR_MAX_T = 4'(HR_MAX / 10);
    localparam logic [BCD_W-1:0] HR_MAX_O = 4'(HR_MAX % 10);

    state_e state_q, state_d;
    logic mode_q, mode_d;
    logic [BCD_W-1:0] hrT_q, hrT_d, hrO_q, hrO_d;
    logic running_q, running_d, done_q, done_d, wrap_q, wrap_d, loadErr_q, loadErr_d;

    logic [BCD_W-1:0] secO, secT, minO, minT;
    logic secOCarry, secOBorrow, secTCarry, secTBorrow;
    logic minOCarry, minOBorrow, minTCarry, minTBorrow;

    logic idleOrPause, modeEff, fieldsOk, loadAccept, loadReject;
    logic cntEn, secTEn, minOEn, minTEn, hrEn;
    logic timeIsZero, timeIsOne, hrAtMax, hrAtZero, doneHit, startDone;

    assign time_bcd = {hrT_q, hrO_q, minT, minO, secT, secO};

    assign idleOrPause = (state_q == IDLE) || (state_q == PAUSE);
    assign modeEff     = idleOrPause ? mode : mode_q;

    // Valid BCD pairs compare correctly as plain 8-bit values, so hours need no binary conversion.
    assign fieldsOk = digitOk(load_bcd[SEC_O_LSB +: BCD_W], DIGIT_MAX)
                   && digitOk(load_bcd[SEC_T_LSB +: BCD_W], SEC_T_MAX)
                   && digitOk(load_bcd[MIN_O_LSB +: BCD_W], DIGIT_MAX)
                   && digitOk(load_bcd[MIN_T_LSB +: BCD_W], MIN_T_MAX)
                   && digitOk(load_bcd[HR_O_LSB +: BCD_W], DIGIT_MAX)
                   && digitOk(load_bcd[HR_T_LSB +: BCD_W], DIGIT_MAX)
                   && ({load_bcd[HR_T_LSB +: BCD_W], load_bcd[HR_O_LSB +: BCD_W]} <= {HR_MAX_T, HR_MAX_O});

    assign loadAccept = load && !clear && idleOrPause && fieldsOk;
    assign loadReject = load && !clear && !(idleOrPause && fieldsOk);

    assign cntEn  = tick && (state_q == RUN) && !clear;
    assign secTEn = secOCarry | secOBorrow;
    assign minOEn = secTCarry | secTBorrow;
    assign minTEn = minOCarry | minOBorrow;
    assign hrEn   = minTCarry | minTBorrow;

    assign timeIsZero = (time_bcd == 24'h000000);
    assign timeIsOne  = (time_bcd == 24'h000001);
    assign hrAtMax    = (hrT_q == HR_MAX_T) && (hrO_q == HR_MAX_O);
    assign hrAtZero   = (hrT_q == '0) && (hrO_q == '0);
    assign doneHit    = cntEn && mode_q && timeIsOne;

    bcd_digit #(.MAX(DIGIT_MAX)) uSecO (
        .clk(clk), .rst(rst), .en(cntEn), .dir(mode_q), .clr(clear), .ld(loadAccept),
        .ld_val(load_bcd[SEC_O_LSB +: BCD_W]), .q(secO), .carry(secOCarry), .borrow(secOBorrow)
    );
    bcd_digit #(.MAX(SEC_T_MAX)) uSecT (
        .clk(clk), .rst(rst), .en(secTEn), .dir(mode_q), .clr(clear), .ld(loadAccept),
        .ld_val(load_bcd[SEC_T_LSB +: BCD_W]), .q(secT), .carry(secTCarry), .borrow(secTBorrow)
    );
    bcd_digit #(.MAX(DIGIT_MAX)) uMinO (
        .clk(clk), .rst(rst), .en(minOEn), .dir(mode_q), .clr(clear), .ld(loadAccept),
        .ld_val(load_bcd[MIN_O_LSB +: BCD_W]), .q(minO), .carry(minOCarry), .borrow(minOBorrow)
    );
    bcd_digit #(.MAX(MIN_T_MAX)) uMinT (
        .clk(clk), .rst(rst), .en(minTEn), .dir(mode_q), .clr(clear), .ld(loadAccept),
        .ld_val(load_bcd[MIN_T_LSB +: BCD_W]), .q(minT), .carry(minTCarry), .borrow(minTBorrow)
    );

    // Hours wrap at HR_MAX rather than a fixed digit limit, so they are counted here as a pair.
    always_comb begin
        hrT_d = hrT_q;
        hrO_d = hrO_q;
        if (clear) begin
            hrT_d = '0;
            hrO_d = '0;
        end else if (loadAccept) begin
            hrT_d = load_bcd[HR_T_LSB +: BCD_W];
            hrO_d = load_bcd[HR_O_LSB +: BCD_W];
        end else if (hrEn) begin
            if (!mode_q) begin
                if (hrAtMax) begin
                    hrT_d = '0;
                    hrO_d = '0;
                end else if (hrO_q == 4'd9) begin
                    hrT_d = hrT_q + 4'd1;
                    hrO_d = '0;
                end else begin
                    hrO_d = hrO_q + 4'd1;
                end
            end else begin
                if (hrAtZero) begin
                    hrT_d = HR_MAX_T;
                    hrO_d = HR_MAX_O;
                end else if (hrO_q == '0) begin
                    hrT_d = hrT_q - 4'd1;
                    hrO_d = 4'd9;
                end else begin
                    hrO_d = hrO_q - 4'd1;
                end
            end
        end
    end

    // Command priority is clear > load > stop > start; expiry overrides the command path.
    always_comb begin
        state_d   = state_q;
        startDone = 1'b0;
        if (clear) begin
            state_d = IDLE;
        end else if (doneHit) begin
            state_d = DONE;
        end else if (load) begin
            state_d = state_q;
        end else if (stop) begin
            if (state_q == RUN) state_d = PAUSE;
        end else if (start && idleOrPause) begin
            if (modeEff && timeIsZero) begin
                state_d   = DONE;
                startDone = 1'b1;
            end else begin
                state_d = RUN;
            end
        end
        mode_d    = modeEff;
        running_d = (state_d == RUN);
        done_d    = doneHit | startDone;
        wrap_d    = hrEn && !mode_q && hrAtMax;
        loadErr_d = loadReject;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            hrT_q     <= '0;
            hrO_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
            loadErr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            hrT_q     <= hrT_d;
            hrO_q     <= hrO_d;
            running_q <= running_d;
            done_q    <= done_d;
            wrap_q    <= wrap_d;
            loadErr_q <= loadErr_d;
        end
    end

    assign running  = running_q;
    assign done     = done_q;
    assign wrap     = wrap_q;
    assign load_err = loadErr_q;

    generate
        if (LAP_EN) begin : gLap
            logic [TIME_W-1:0] lap_q;
            logic              lapValid_q;

            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    lap_q      <= '0;
                    lapValid_q <= 1'b0;
                end else if (lap && (state_q != IDLE)) begin
                    lap_q      <= time_bcd;
                    lapValid_q <= 1'b1;
                end
            end

            assign lap_bcd   = lap_q;
            assign lap_valid = lapValid_q;
        end else begin : gNoLap
            assign lap_bcd   = '0;
            assign lap_valid = 1'b0;
        end
    endgenerate

endmodule

// File: doc/timer_core.md
# timer_core

Parametrised second-generation stopwatch/timer counter: six BCD digits (HH:MM:SS) advanced by a one-cycle 1 Hz enable strobe. It adds count-down mode with expiry, preset load with validation, lap capture, and a configurable hour ceiling. It sits between the 1 Hz prescaler and the seven-segment display multiplexer and is driven by the debounced button/control logic.

## Interface
- HR_MAX, 99: highest hour value before up-count wrap; legal 1..99.
- LAP_EN, 1: 1 instantiates lap registers; 0 ties lap_bcd to 0 and lap_valid to 0.

- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  1 Hz enable strobe, one clk cycle wide.
- start  in  1  pulse; enter RUN.
- stop  in  1  pulse; RUN → PAUSE.
- clear  in  1  pulse; zero the time and go IDLE.
- mode  in  1  0 = count up, 1 = count down; sampled only in IDLE/PAUSE.
- load  in  1  pulse; load load_bcd, accepted only in IDLE/PAUSE.
- load_bcd  in  24  preset {hr_t,hr_o,min_t,min_o,sec_t,sec_o}, 4 bits each.
- lap  in  1  pulse; capture time_bcd into lap_bcd.
- time_bcd  out  24  current time, same packing as load_bcd.
- lap_bcd  out  24  last captured time.
- lap_valid  out  1  high once a lap has been captured since the last clear/reset.
- running  out  1  high in RUN.
- done  out  1  one-cycle pulse when a count-down reaches 00:00:00.
- wrap  out  1  one-cycle pulse on an up-count rollover HR_MAX:59:59 → 00:00:00.
- load_err  out  1  one-cycle pulse when a load is rejected.

## Operation
- States:
  - IDLE: after reset or clear.
  - RUN: counting.
  - PAUSE: stopped by stop.
  - DONE: count-down expired.
- Transitions:
  - IDLE/PAUSE --start→ RUN.
  - RUN --stop→ PAUSE.
  - RUN (down) reaching zero → DONE.
  - any state --clear→ IDLE.
  - DONE --start→ DONE, with start ignored.
- Start in down mode with time 00:00:00 goes directly to DONE and pulses done.
- The latched mode register updates from the mode input every cycle in IDLE/PAUSE and holds in RUN/DONE.
- Up count on tick in RUN:
  - Each digit increments, carrying at sec_o 9, sec_t 5, min_o 9, min_t 5.
  - Hours count as a decimal pair up to HR_MAX.
  - At HR_MAX:59:59 the time goes to 00:00:00 with a wrap pulse and counting continues.
- Down count on tick in RUN:
  - Each digit decrements, borrowing from 0 to 9 (sec_o/min_o) or 0 to 5 (sec_t/min_t).
  - On reaching 00:00:00 the FSM enters DONE, running drops, and done pulses in the same cycle the zero appears.
- Load:
  - Rejected, with load_err and no change to time or state, if any of these hold: state is RUN/DONE; any digit is >9; sec_t or min_t is >5; hours are >HR_MAX.
- Lap:
  - Captures the pre-update time_bcd in any state except IDLE and sets lap_valid.
  - clear/rst zero lap_bcd and lap_valid.
- Same-cycle priority: rst > clear > load > stop > start.
  - lap is independent and samples the register value before that cycle's update.
- tick is counted only if the registered state is RUN in that cycle, so tick in the same cycle as start is not counted.
  - tick in the same cycle as stop is counted.

## Timing
- Reset values: time_bcd 0, lap_bcd 0, lap_valid 0, running 0, done 0, wrap 0, load_err 0, state IDLE, latched mode 0.
- All outputs are registered.
  - time_bcd reflects a tick one cycle after the tick.
  - running reflects start/stop one cycle later.
- done, wrap and load_err are exactly one cycle wide and coincide with the time_bcd update that caused them.
- Reset mid-count takes effect on the next clk edge regardless of tick.
- No combinational path from any input to any output.

## Structure
- timer_pkg:
  - state enum (IDLE, RUN, PAUSE, DONE).
  - digit-limit constants SEC_T_MAX = 5 and MIN_T_MAX = 5.
  - BCD_W = 4 and TIME_W = 24.
  - field offsets for the packed time word.
- Sub-module bcd_digit:
  - parameter MAX.
  - inputs en, dir, clr, ld, ld_val.
  - outputs q, carry (q == MAX while up and enabled) and borrow (q == 0 while down and enabled).
  - Instantiated four times for sec/min.
  - Hours are handled in the parent for the HR_MAX compare.

## Test plan
- Up count from 00:00:00 with 60 ticks → 00:01:00; 3600 ticks total → 01:00:00.
- HR_MAX = 23, load 23:59:59, mode up, start, 1 tick → 00:00:00, wrap pulses one cycle, running stays 1.
- Load 00:00:02, mode down, start, 2 ticks → 00:00:00, done pulses, state DONE, further ticks leave 00:00:00.
- Load 00:61:00 while in IDLE → load_err pulses, time unchanged; load 00:10:00 while in RUN → load_err pulses.
- Running at 00:00:07, lap then stop, with tick in the same cycle as stop → lap_bcd 00:00:07, time 00:00:08, running 0.
- rst asserted mid-count at 12:34:56 with tick high → next cycle all outputs 0, state IDLE.
